// File: rtl/usb_ep0_controller.sv
// Endpoint-0 control-transfer sequencer: parses SETUP packets, streams descriptors from ROM
// as toggled IN packets with retry and terminating ZLP, and handles SET_ADDRESS / SET_CONFIGURATION.
module usb_ep0_controller #(
    parameter int MAX_PACKET = 64,
    parameter int ROM_AW     = 10,
    parameter int DEV_OFFSET = 0,
    parameter int DEV_LENGTH = 18,
    parameter int CFG_OFFSET = 18,
    parameter int CFG_LENGTH = 32
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              ResetRequest,
    input  logic [3:0]        Endpoint,
    input  logic              Error,
    input  logic              OUT_Setup,
    input  logic              OUT_SoP,
    input  logic              OUT_EoP,
    input  logic [7:0]        OUT_Data,
    input  logic              OUT_Valid,
    input  logic              IN_WaitRequest,
    input  logic              IN_Ack,
    input  logic [7:0]        Rom_Data,
    output logic [ROM_AW-1:0] Rom_Address,
    output logic [7:0]        IN_Data,
    output logic              IN_Ready,
    output logic              IN_ZeroLength,
    output logic              IN_Sequence,
    output logic [6:0]        Address,
    output logic [7:0]        Configuration,
    output logic              Stall
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_SETUP      = 4'd1;
    localparam logic [3:0] ST_DECODE     = 4'd2;
    localparam logic [3:0] ST_PRIME      = 4'd3;
    localparam logic [3:0] ST_SEND       = 4'd4;
    localparam logic [3:0] ST_WAIT_ACK   = 4'd5;
    localparam logic [3:0] ST_ZLP        = 4'd6;
    localparam logic [3:0] ST_STATUS_IN  = 4'd7;
    localparam logic [3:0] ST_STATUS_OUT = 4'd8;

    localparam logic [7:0] REQ_SET_ADDRESS    = 8'h05;
    localparam logic [7:0] REQ_GET_DESCRIPTOR = 8'h06;
    localparam logic [7:0] REQ_SET_CONFIG     = 8'h09;

    logic [3:0]        state;
    logic [2:0]        byte_idx;
    logic [7:0]        bm_request;
    logic [7:0]        b_request;
    logic [15:0]       w_value;
    logic [15:0]       w_length;
    logic [15:0]       len;
    logic [15:0]       remaining;
    logic [6:0]        byte_count;
    logic [ROM_AW-1:0] rom_addr;
    logic [6:0]        pending_addr;
    logic              addr_pending;

    logic        ep0, setup_start, host_out_done, consume, in_ack, in_err, last_byte;
    logic        is_get_desc;
    logic [6:0]  byte_count_inc;
    logic [15:0] remaining_after, dev_len, cfg_len;

    assign ep0             = (Endpoint == 4'd0);
    assign setup_start     = OUT_Valid & OUT_SoP & OUT_Setup & ep0;
    assign host_out_done   = OUT_EoP & ~OUT_Setup & ep0;
    assign consume         = IN_Ready & ~IN_WaitRequest & ep0;
    assign in_ack          = IN_Ack & ep0;
    assign in_err          = Error & ep0;
    assign byte_count_inc  = byte_count + 7'd1;
    // A packet ends when it is full or when it exhausts what is still owed to the host
    assign last_byte       = (byte_count_inc == 7'(MAX_PACKET)) || ({9'd0, byte_count_inc} == remaining);
    assign remaining_after = remaining - {9'd0, byte_count};
    assign dev_len         = (w_length < 16'(DEV_LENGTH)) ? w_length : 16'(DEV_LENGTH);
    assign cfg_len         = (w_length < 16'(CFG_LENGTH)) ? w_length : 16'(CFG_LENGTH);
    assign is_get_desc     = (bm_request == 8'h80) && (b_request == REQ_GET_DESCRIPTOR) && (w_length != 16'd0);

    assign Rom_Address = rom_addr;
    assign IN_Data     = (state == ST_SEND) ? Rom_Data : 8'h00;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= ST_IDLE;  byte_idx <= '0;  bm_request <= '0;  b_request <= '0;
            w_value <= '0;  w_length <= '0;  len <= '0;  remaining <= '0;
            byte_count <= '0;  rom_addr <= '0;  pending_addr <= '0;  addr_pending <= 1'b0;
            IN_Ready <= 1'b0;  IN_ZeroLength <= 1'b0;  IN_Sequence <= 1'b0;
            Address <= '0;  Configuration <= '0;  Stall <= 1'b0;
        end else if (ResetRequest) begin
            state <= ST_IDLE;  byte_idx <= '0;  bm_request <= '0;  b_request <= '0;
            w_value <= '0;  w_length <= '0;  len <= '0;  remaining <= '0;
            byte_count <= '0;  rom_addr <= '0;  pending_addr <= '0;  addr_pending <= 1'b0;
            IN_Ready <= 1'b0;  IN_ZeroLength <= 1'b0;  IN_Sequence <= 1'b0;
            Address <= '0;  Configuration <= '0;  Stall <= 1'b0;
        end else if (setup_start) begin
            // A new SETUP always wins, abandoning whatever transfer was in flight
            state         <= ST_SETUP;
            byte_idx      <= 3'd1;
            bm_request    <= OUT_Data;
            Stall         <= 1'b0;
            IN_Ready      <= 1'b0;
            IN_ZeroLength <= 1'b0;
            addr_pending  <= 1'b0;
        end else begin
            case (state)
                ST_SETUP: begin
                    if (OUT_Valid && ep0) begin
                        case (byte_idx)
                            3'd1:    b_request      <= OUT_Data;
                            3'd2:    w_value[7:0]   <= OUT_Data;
                            3'd3:    w_value[15:8]  <= OUT_Data;
                            3'd6:    w_length[7:0]  <= OUT_Data;
                            3'd7:    w_length[15:8] <= OUT_Data;
                            default: ;
                        endcase
                        byte_idx <= byte_idx + 3'd1;
                        if (byte_idx == 3'd7) state <= ST_DECODE;
                    end else if (OUT_EoP && ep0) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DECODE: begin
                    byte_count <= '0;
                    if (is_get_desc && w_value[15:8] == 8'd1) begin
                        len         <= dev_len;
                        remaining   <= dev_len;
                        rom_addr    <= ROM_AW'(DEV_OFFSET);
                        IN_Sequence <= 1'b1;
                        state       <= ST_PRIME;
                    end else if (is_get_desc && w_value[15:8] == 8'd2) begin
                        len         <= cfg_len;
                        remaining   <= cfg_len;
                        rom_addr    <= ROM_AW'(CFG_OFFSET);
                        IN_Sequence <= 1'b1;
                        state       <= ST_PRIME;
                    end else if (bm_request == 8'h00 &&
                                 (b_request == REQ_SET_ADDRESS || b_request == REQ_SET_CONFIG)) begin
                        // The new address takes effect only once the status ZLP is acknowledged
                        if (b_request == REQ_SET_ADDRESS) begin
                            pending_addr <= w_value[6:0];
                            addr_pending <= 1'b1;
                        end else begin
                            Configuration <= w_value[7:0];
                        end
                        IN_Ready      <= 1'b1;
                        IN_ZeroLength <= 1'b1;
                        IN_Sequence   <= 1'b1;
                        state         <= ST_STATUS_IN;
                    end else begin
                        Stall <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    IN_Ready <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (host_out_done) begin
                        IN_Ready <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (consume) begin
                        rom_addr   <= rom_addr + 1'b1;
                        byte_count <= byte_count_inc;
                        IN_Ready   <= 1'b0;
                        if (last_byte) state <= ST_WAIT_ACK;
                    end else begin
                        IN_Ready <= 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (host_out_done) begin
                        state <= ST_IDLE;
                    end else if (in_ack) begin
                        remaining   <= remaining_after;
                        IN_Sequence <= ~IN_Sequence;
                        byte_count  <= '0;
                        if (remaining_after != 16'd0) begin
                            state <= ST_PRIME;
                        end else if (byte_count == 7'(MAX_PACKET) && len < w_length) begin
                            IN_Ready      <= 1'b1;
                            IN_ZeroLength <= 1'b1;
                            state         <= ST_ZLP;
                        end else begin
                            state <= ST_STATUS_OUT;
                        end
                    end else if (in_err) begin
                        // Rewind so the identical packet goes out again with the same toggle
                        rom_addr   <= rom_addr - ROM_AW'(byte_count);
                        byte_count <= '0;
                        state      <= ST_PRIME;
                    end
                end
                ST_ZLP: begin
                    if (host_out_done) begin
                        IN_Ready      <= 1'b0;
                        IN_ZeroLength <= 1'b0;
                        state         <= ST_IDLE;
                    end else if (in_ack) begin
                        IN_Ready      <= 1'b0;
                        IN_ZeroLength <= 1'b0;
                        state         <= ST_STATUS_OUT;
                    end
                end
                ST_STATUS_IN: begin
                    if (in_ack) begin
                        IN_Ready      <= 1'b0;
                        IN_ZeroLength <= 1'b0;
                        addr_pending  <= 1'b0;
                        if (addr_pending) Address <= pending_addr;
                        state <= ST_IDLE;
                    end
                end
                ST_STATUS_OUT: begin
                    if (host_out_done) state <= ST_IDLE;
                end
                ST_IDLE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_ep0_controller.sv
// Scoreboard bench for usb_ep0_controller: expected IN bytes are queued when a SETUP is issued
// and popped as the DUT streams them; a behavioural ROM supplies data with one cycle of latency.
module tb_usb_ep0_controller;

    localparam int ROM_AW = 10;

    logic              Clk = 1'b0;
    logic              nReset, ResetRequest, Error, OUT_Setup, OUT_SoP, OUT_EoP, OUT_Valid;
    logic              IN_WaitRequest, IN_Ack;
    logic [3:0]        Endpoint;
    logic [7:0]        OUT_Data, Rom_Data, IN_Data, Configuration;
    logic [ROM_AW-1:0] Rom_Address;
    logic              IN_Ready, IN_ZeroLength, IN_Sequence, Stall;
    logic [6:0]        Address;

    typedef struct {
        logic [7:0] data;
        logic       seq;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    usb_ep0_controller #(
        .MAX_PACKET(64), .ROM_AW(ROM_AW), .DEV_OFFSET(0), .DEV_LENGTH(18),
        .CFG_OFFSET(18), .CFG_LENGTH(64)
    ) u_dut (
        .Clk(Clk), .nReset(nReset), .ResetRequest(ResetRequest), .Endpoint(Endpoint),
        .Error(Error), .OUT_Setup(OUT_Setup), .OUT_SoP(OUT_SoP), .OUT_EoP(OUT_EoP),
        .OUT_Data(OUT_Data), .OUT_Valid(OUT_Valid), .IN_WaitRequest(IN_WaitRequest),
        .IN_Ack(IN_Ack), .Rom_Data(Rom_Data), .Rom_Address(Rom_Address), .IN_Data(IN_Data),
        .IN_Ready(IN_Ready), .IN_ZeroLength(IN_ZeroLength), .IN_Sequence(IN_Sequence),
        .Address(Address), .Configuration(Configuration), .Stall(Stall)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] romByte(input logic [ROM_AW-1:0] a);
        logic [15:0] t;
        t = {6'd0, a} * 16'd37 + 16'd11;
        return t[7:0];
    endfunction

    always @(posedge Clk) Rom_Data <= romByte(Rom_Address);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic pushBytes(input int offset, input int n, input logic seq);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = romByte(ROM_AW'(offset + i));
            e.seq  = seq;
            expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] pkt, input logic [3:0] ep, input bit checkStall);
        @(posedge Clk); #1;
        for (int i = 0; i < 8; i++) begin
            Endpoint  = ep;
            OUT_Setup = 1'b1;
            OUT_Valid = 1'b1;
            OUT_SoP   = (i == 0);
            OUT_Data  = pkt[63-8*i -: 8];
            @(posedge Clk); #1;
            if (i == 0 && checkStall) checkOutput("stall_clear", 32'(Stall), 32'd0);
        end
        OUT_Valid = 1'b0;
        OUT_SoP   = 1'b0;
        OUT_EoP   = 1'b1;
        @(posedge Clk); #1;
        OUT_EoP   = 1'b0;
        OUT_Setup = 1'b0;
        Endpoint  = 4'd0;
    endtask

    // Host side of one data packet; the packet is over once IN_Ready stays low
    task automatic readPacket(input string tag, input int expCount);
        int   waitCnt, count, idle;
        exp_t e;
        waitCnt = 0; count = 0; idle = 0;
        @(negedge Clk);
        while (!IN_Ready && waitCnt < 20) begin
            @(negedge Clk);
            waitCnt++;
        end
        checkOutput({tag, "_ready"}, 32'(IN_Ready), 32'd1);
        while (idle < 3 && count < 100) begin
            if (IN_Ready && !IN_ZeroLength) begin
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput({tag, "_data"}, 32'(IN_Data), 32'(e.data));
                    checkOutput({tag, "_seq"}, 32'(IN_Sequence), 32'(e.seq));
                end
                count++;
                idle = 0;
            end else begin
                idle++;
            end
            @(negedge Clk);
        end
        checkOutput({tag, "_len"}, 32'(count), 32'(expCount));
    endtask

    task automatic pulseAck();
        IN_Ack = 1'b1;
        @(negedge Clk);
        IN_Ack = 1'b0;
    endtask

    task automatic pulseError();
        Error = 1'b1;
        @(negedge Clk);
        Error = 1'b0;
    endtask

    task automatic statusOut();
        OUT_EoP = 1'b1;
        @(negedge Clk);
        OUT_EoP = 1'b0;
    endtask

    task automatic checkNoZlp(input string tag);
        @(negedge Clk);
        checkOutput({tag, "_nozlp_rdy"}, 32'(IN_Ready), 32'd0);
        checkOutput({tag, "_nozlp_zl"}, 32'(IN_ZeroLength), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitCnt;
        nReset = 1'b0; ResetRequest = 1'b0; Endpoint = 4'd0; Error = 1'b0;
        OUT_Setup = 1'b0; OUT_SoP = 1'b0; OUT_EoP = 1'b0; OUT_Data = 8'h00; OUT_Valid = 1'b0;
        IN_WaitRequest = 1'b0; IN_Ack = 1'b0;
        repeat (2) @(negedge Clk);
        checkOutput("rst_ready", 32'(IN_Ready), 32'd0);
        checkOutput("rst_addr", 32'(Address), 32'd0);
        checkOutput("rst_cfg", 32'(Configuration), 32'd0);
        checkOutput("rst_stall", 32'(Stall), 32'd0);
        checkOutput("rst_rom", 32'(Rom_Address), 32'd0);
        checkOutput("rst_seq", 32'(IN_Sequence), 32'd0);
        nReset = 1'b1;

        // Device descriptor, host asks for more than exists
        pushBytes(0, 18, 1'b1);
        applyStimulus(64'h80_06_00_01_00_00_40_00, 4'd0, 1'b0);
        readPacket("dev64", 18);
        pulseAck();
        checkNoZlp("dev64");
        statusOut();

        // Device descriptor truncated by wLength
        pushBytes(0, 8, 1'b1);
        applyStimulus(64'h80_06_00_01_00_00_08_00, 4'd0, 1'b0);
        readPacket("dev8", 8);
        pulseAck();
        checkNoZlp("dev8");
        statusOut();

        // Full-size configuration packet followed by a DATA0 ZLP
        pushBytes(18, 64, 1'b1);
        applyStimulus(64'h80_06_00_02_00_00_FF_00, 4'd0, 1'b0);
        readPacket("cfg255", 64);
        pulseAck();
        @(negedge Clk);
        checkOutput("zlp_ready", 32'(IN_Ready), 32'd1);
        checkOutput("zlp_zl", 32'(IN_ZeroLength), 32'd1);
        checkOutput("zlp_seq", 32'(IN_Sequence), 32'd0);
        pulseAck();
        checkOutput("zlp_done", 32'(IN_Ready), 32'd0);
        statusOut();

        // Error in WaitAck: identical packet resent, then exact-length request ends without ZLP
        pushBytes(18, 64, 1'b1);
        applyStimulus(64'h80_06_00_02_00_00_40_00, 4'd0, 1'b0);
        readPacket("cfg64", 64);
        pushBytes(18, 64, 1'b1);
        pulseError();
        readPacket("cfg64_retry", 64);
        pulseAck();
        checkNoZlp("cfg64");
        statusOut();

        // SET_ADDRESS: address applies only on the status-stage ACK
        applyStimulus(64'h00_05_05_00_00_00_00_00, 4'd0, 1'b0);
        @(negedge Clk);
        checkOutput("addr_st_ready", 32'(IN_Ready), 32'd1);
        checkOutput("addr_st_zl", 32'(IN_ZeroLength), 32'd1);
        checkOutput("addr_st_seq", 32'(IN_Sequence), 32'd1);
        checkOutput("addr_before", 32'(Address), 32'd0);
        pulseError();
        checkOutput("addr_after_err", 32'(Address), 32'd0);
        checkOutput("addr_resend_zl", 32'(IN_ZeroLength), 32'd1);
        pulseAck();
        checkOutput("addr_after_ack", 32'(Address), 32'd5);
        checkOutput("addr_done", 32'(IN_Ready), 32'd0);

        applyStimulus(64'h00_09_03_00_00_00_00_00, 4'd0, 1'b0);
        @(negedge Clk);
        pulseAck();
        checkOutput("set_cfg", 32'(Configuration), 32'd3);

        // Unsupported requests stall; a SETUP on another endpoint is ignored
        applyStimulus(64'h82_0C_00_00_00_00_02_00, 4'd0, 1'b0);
        @(negedge Clk);
        checkOutput("stall_synch", 32'(Stall), 32'd1);
        applyStimulus(64'h80_06_00_01_00_00_40_00, 4'd3, 1'b0);
        repeat (3) @(negedge Clk);
        checkOutput("stall_ep3", 32'(Stall), 32'd1);
        checkOutput("ep3_idle", 32'(IN_Ready), 32'd0);
        pushBytes(0, 8, 1'b1);
        applyStimulus(64'h80_06_00_01_00_00_08_00, 4'd0, 1'b1);
        readPacket("after_stall", 8);
        pulseAck();
        statusOut();
        applyStimulus(64'h80_06_00_03_00_00_40_00, 4'd0, 1'b0);
        @(negedge Clk);
        checkOutput("stall_strdesc", 32'(Stall), 32'd1);
        applyStimulus(64'h80_06_00_01_00_00_00_00, 4'd0, 1'b0);
        @(negedge Clk);
        checkOutput("stall_wlen0", 32'(Stall), 32'd1);

        // Asynchronous reset in the middle of Send
        applyStimulus(64'h80_06_00_01_00_00_40_00, 4'd0, 1'b0);
        waitCnt = 0;
        @(negedge Clk);
        while (!IN_Ready && waitCnt < 20) begin
            @(negedge Clk);
            waitCnt++;
        end
        checkOutput("mid_send_ready", 32'(IN_Ready), 32'd1);
        #2 nReset = 1'b0;
        #1;
        checkOutput("nrst_ready", 32'(IN_Ready), 32'd0);
        checkOutput("nrst_data", 32'(IN_Data), 32'd0);
        checkOutput("nrst_addr", 32'(Address), 32'd0);
        checkOutput("nrst_cfg", 32'(Configuration), 32'd0);
        checkOutput("nrst_rom", 32'(Rom_Address), 32'd0);
        checkOutput("nrst_seq", 32'(IN_Sequence), 32'd0);
        checkOutput("nrst_stall", 32'(Stall), 32'd0);
        expQ.delete();
        @(negedge Clk);
        nReset = 1'b1;

        pushBytes(0, 8, 1'b1);
        applyStimulus(64'h80_06_00_01_00_00_08_00, 4'd0, 1'b0);
        readPacket("post_rst", 8);
        pulseAck();
        statusOut();

        // Bus reset from the transceiver clears configuration synchronously
        applyStimulus(64'h00_09_07_00_00_00_00_00, 4'd0, 1'b0);
        @(negedge Clk);
        pulseAck();
        checkOutput("cfg7", 32'(Configuration), 32'd7);
        ResetRequest = 1'b1;
        @(negedge Clk);
        ResetRequest = 1'b0;
        checkOutput("busrst_cfg", 32'(Configuration), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
